l1_line_cache: RTL and testbench

//   Direct-mapped, write-back, virtually indexed/tagged L1 cache serving 32-bit CPU word accesses.

---
 rtl/l1_line_cache_if.sv | 44 ++++
 rtl/l1_line_cache.sv | 215 +++++++++++++++++++++
 tb/tb_l1_line_cache.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_line_cache_if.sv
// CPU-side and mmu-side signals of the L1 line cache grouped into one bundle.
// Signal suffixes describe direction as seen from the cache: _i enters the
// cache and _o leaves it. The cache uses the slave modport. The CPU and mmu
// side (or a testbench standing in for them) uses the master modport.
interface l1_line_cache_if;
  // CPU word port
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [3:0]   cpu_sel_i;
  logic         cpu_rd_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_ack_o;
  logic         cpu_fault_o;
  // flush handshake
  logic         flush_i;
  logic         flush_done_o;
  // mmu virtual-side line port
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_rd_o;
  logic         mem_we_o;
  logic         mem_ack_i;
  logic         mem_fault_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_sel_i, cpu_rd_i, cpu_we_i,
    output cpu_data_o, cpu_ack_o, cpu_fault_o,
    input  flush_i,
    output flush_done_o,
    output mem_addr_o, mem_data_o, mem_rd_o, mem_we_o,
    input  mem_data_i, mem_ack_i, mem_fault_i
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_sel_i, cpu_rd_i, cpu_we_i,
    input  cpu_data_o, cpu_ack_o, cpu_fault_o,
    output flush_i,
    input  flush_done_o,
    input  mem_addr_o, mem_data_o, mem_rd_o, mem_we_o,
    output mem_data_i, mem_ack_i, mem_fault_i
  );
endinterface

// File: rtl/l1_line_cache.sv
// Direct-mapped, write-back, virtually indexed/tagged L1 cache with 32-byte
// lines. Hits acknowledge in the same cycle. Misses evict a dirty victim and
// then fill the line over the mmu port. An mmu page fault ends the CPU access
// with a faulting acknowledge. A flush walks every line once, writes back the
// dirty ones and invalidates them all.
module l1_line_cache #(
  parameter int LINES = 64
) (
  input  logic             clk,
  input  logic             rst,
  l1_line_cache_if.slave   bus
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = 27 - IDX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FAULT,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next;

  // line bookkeeping
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [255:0]        r_data [LINES];

  // registered mmu request and the miss it belongs to
  logic [31:0]         r_mem_addr;
  logic [255:0]        r_mem_data;
  logic [IDX_BITS-1:0] r_req_idx;
  logic [TAG_BITS-1:0] r_req_tag;

  // flush walk: line counter and "write-back outstanding for this line"
  logic [IDX_BITS-1:0] r_fcnt;
  logic                r_fl_busy;

  // CPU address decode
  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic [2:0]          w_word;
  logic [255:0]        w_line;
  logic                w_req;
  logic                w_lookup_hit;
  logic                w_hit;
  logic                w_miss;
  logic                w_victim_dirty;
  logic                w_fl_dirty;
  logic                w_fl_line_done;
  logic                w_fl_last;
  logic                w_unused_addr;

  assign w_idx          = bus.cpu_addr_i[IDX_BITS+4:5];
  assign w_tag          = bus.cpu_addr_i[31:IDX_BITS+5];
  assign w_word         = bus.cpu_addr_i[4:2];
  assign w_unused_addr  = &{1'b0, bus.cpu_addr_i[1:0]};
  assign w_line         = r_data[w_idx];
  assign w_req          = bus.cpu_rd_i | bus.cpu_we_i;
  assign w_lookup_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit          = (r_state == S_IDLE) && w_req && w_lookup_hit;
  // a flush request takes priority over a miss arriving in the same cycle
  assign w_miss         = (r_state == S_IDLE) && w_req && !w_lookup_hit && !bus.flush_i;
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];

  // a flushed line is finished once its write-back has been acked,
  // or at once if it holds nothing to write back
  assign w_fl_dirty     = r_valid[r_fcnt] && r_dirty[r_fcnt];
  assign w_fl_line_done = (r_state == S_FLUSH) &&
                          (r_fl_busy ? bus.mem_ack_i : !w_fl_dirty);
  assign w_fl_last      = w_fl_line_done && (r_fcnt == IDX_BITS'(LINES - 1));

  assign bus.cpu_data_o = w_line[32*int'(w_word) +: 32];
  assign bus.mem_addr_o = r_mem_addr;
  assign bus.mem_data_o = r_mem_data;

  // state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    // NOTE: w_next gets a default before the case, so no path through the
    // block leaves it unassigned and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.flush_i)  w_next = S_FLUSH;
        else if (w_miss)  w_next = w_victim_dirty ? S_WB : S_FILL;
      end
      S_WB: begin
        if (bus.mem_ack_i) w_next = bus.mem_fault_i ? S_FAULT : S_FILL;
      end
      S_FILL: begin
        if (bus.mem_ack_i) w_next = bus.mem_fault_i ? S_FAULT : S_IDLE;
      end
      S_FAULT: w_next = S_IDLE;
      S_FLUSH: begin
        if (w_fl_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    bus.cpu_ack_o    = 1'b0;
    bus.cpu_fault_o  = 1'b0;
    bus.flush_done_o = 1'b0;
    bus.mem_rd_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    unique case (r_state)
      S_IDLE:  bus.cpu_ack_o = w_hit;
      S_WB:    bus.mem_we_o  = 1'b1;
      S_FILL:  bus.mem_rd_o  = 1'b1;
      S_FAULT: begin
        // the faulting ack only goes out while the CPU still requests
        bus.cpu_ack_o   = w_req;
        bus.cpu_fault_o = w_req;
      end
      S_FLUSH: begin
        bus.mem_we_o     = r_fl_busy;
        bus.flush_done_o = w_fl_last;
      end
      default: ;
    endcase
  end

  // valid/dirty bits, mmu request registers, miss context and flush walk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_req_idx  <= '0;
      r_req_tag  <= '0;
      r_fcnt     <= '0;
      r_fl_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit && bus.cpu_we_i) r_dirty[w_idx] <= 1'b1;
          if (bus.flush_i) begin
            r_fcnt    <= '0;
            r_fl_busy <= 1'b0;
          end else if (w_miss) begin
            r_req_idx <= w_idx;
            r_req_tag <= w_tag;
            if (w_victim_dirty) begin
              r_mem_addr <= {r_tag[w_idx], w_idx, 5'b0};
              r_mem_data <= r_data[w_idx];
            end else begin
              r_mem_addr <= {w_tag, w_idx, 5'b0};
            end
          end
        end
        S_WB: begin
          // a faulted eviction leaves the victim dirty and the address as is
          if (bus.mem_ack_i && !bus.mem_fault_i) begin
            r_dirty[r_req_idx] <= 1'b0;
            r_mem_addr         <= {r_req_tag, r_req_idx, 5'b0};
          end
        end
        S_FILL: begin
          if (bus.mem_ack_i && !bus.mem_fault_i) begin
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (!r_fl_busy && w_fl_dirty) begin
            r_fl_busy  <= 1'b1;
            r_mem_addr <= {r_tag[r_fcnt], r_fcnt, 5'b0};
            r_mem_data <= r_data[r_fcnt];
          end else if (w_fl_line_done) begin
            // a faulted flush write-back is dropped; the line goes regardless
            r_fl_busy       <= 1'b0;
            r_valid[r_fcnt] <= 1'b0;
            r_dirty[r_fcnt] <= 1'b0;
            r_fcnt          <= r_fcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // line data and tag storage: write-hit byte merge and fill install
  always_ff @(posedge clk) begin
    // NOTE: the data and tag arrays are deliberately not reset; the valid bits
    // alone decide whether their contents are used, so clearing them would
    // only cost reset fan-out.
    if (w_hit && bus.cpu_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_sel_i[b])
          r_data[w_idx][32*int'(w_word) + 8*b +: 8] <= bus.cpu_data_i[8*b +: 8];
      end
    end
    if ((r_state == S_FILL) && bus.mem_ack_i && !bus.mem_fault_i) begin
      r_data[r_req_idx] <= bus.mem_data_i;
      r_tag[r_req_idx]  <= r_req_tag;
    end
  end

endmodule

// File: tb/tb_l1_line_cache.sv
// Directed testbench for l1_line_cache (64 lines). The bench plays the CPU and
// the mmu. A line-level model of the cache predicts every mmu transfer and
// every CPU acknowledge. One compare process checks the DUT against that model
// at each falling edge. Literal expectations from the cache's documented
// scenarios pin the model itself.
module tb_l1_line_cache;

  localparam int LINES = 64;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  l1_line_cache_if bus ();

  l1_line_cache #(.LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // counters and bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int last_mem_ack_cyc = -1;
  int last_cpu_ack_cyc = -1;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  logic [31:0]  wr_log [$];

  // model state
  bit           m_valid [LINES];
  bit           m_dirty [LINES];
  logic [20:0]  m_tag   [LINES];
  logic [255:0] m_line  [LINES];
  logic [255:0] bmem    [logic [31:0]];
  mem_txn_t     exp_mem [$];

  // expectations handed from the stimulus to the compare process
  bit          ack_expected   = 1'b0;
  bit          exp_ack_fault  = 1'b0;
  logic [31:0] exp_ack_data   = '0;
  bit          flush_pending  = 1'b0;
  bit          f_wb_flag      = 1'b0;
  bit          f_fill_flag    = 1'b0;
  int          lat            = 2;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // backing memory seen through the mmu; untouched lines follow a pattern
  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = (la + 32'(4 * w)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // predict one CPU access: queued mmu transfers, fault outcome, read word
  task automatic model_access(input logic [31:0] addr, input bit we, input logic [3:0] sel,
                              input logic [31:0] wd, input bit f_wb, input bit f_fill,
                              output bit hit, output bit flt, output logic [31:0] rd);
    int          idx;
    int          w;
    logic [20:0] tag;
    idx = int'(addr[10:5]);
    w   = int'(addr[4:2]);
    tag = addr[31:11];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    flt = 1'b0;
    rd  = '0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_mem.push_back('{1'b1, {m_tag[idx], 6'(idx), 5'b0}, m_line[idx]});
        if (f_wb) flt = 1'b1;
        else      m_dirty[idx] = 1'b0;
      end
      if (!flt) begin
        exp_mem.push_back('{1'b0, {tag, 6'(idx), 5'b0}, 256'b0});
        if (f_fill) flt = 1'b1;
        else begin
          m_line[idx]  = mem_line({addr[31:5], 5'b0});
          m_valid[idx] = 1'b1;
          m_dirty[idx] = 1'b0;
          m_tag[idx]   = tag;
        end
      end
    end
    if (!flt) begin
      rd = m_line[idx][32*w +: 32];
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_line[idx][32*w + 8*b +: 8] = wd[8*b +: 8];
        m_dirty[idx] = 1'b1;
      end
    end
  endtask

  // mmu responder: acks each line request after lat idle cycles
  initial begin
    int busy;
    busy = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_fault_i = 1'b0;
    bus.mem_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_fault_i = 1'b0;
      if (rst || !(bus.mem_rd_o || bus.mem_we_o)) begin
        busy = 0;
      end else if (busy >= lat) begin
        busy = 0;
        bus.mem_ack_i = 1'b1;
        if (bus.mem_rd_o) begin
          bus.mem_fault_i = f_fill_flag;
          bus.mem_data_i  = mem_line(bus.mem_addr_o);
        end else begin
          bus.mem_fault_i = f_wb_flag;
          if (!f_wb_flag) bmem[bus.mem_addr_o] = bus.mem_data_o;
        end
      end else begin
        busy++;
      end
    end
  end

  // compare process: DUT outputs against the model, every falling edge
  initial begin
    bit          mem_seen;
    logic [31:0] cur_addr;
    mem_txn_t    e;
    mem_seen = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_seen = 1'b0;
      end else begin
        if (bus.mem_rd_o && bus.mem_we_o) check("mem_rd_we_both", 1, 0);
        if ((bus.mem_rd_o || bus.mem_we_o) && !mem_seen) begin
          mem_seen = 1'b1;
          cur_addr = bus.mem_addr_o;
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_req", {bus.mem_we_o, bus.mem_addr_o}, 0);
          end else begin
            e = exp_mem.pop_front();
            check("mem_is_write", bus.mem_we_o, e.wr);
            check("mem_addr", bus.mem_addr_o, e.addr);
            if (e.wr) check("mem_wdata", bus.mem_data_o, e.data);
          end
          if (bus.mem_we_o) begin
            n_wr++;
            last_wr_addr = bus.mem_addr_o;
            last_wr_data = bus.mem_data_o;
            wr_log.push_back(bus.mem_addr_o);
          end else begin
            n_rd++;
            last_rd_addr = bus.mem_addr_o;
          end
        end else if (mem_seen && (bus.mem_rd_o || bus.mem_we_o)) begin
          if (bus.mem_addr_o !== cur_addr) check("mem_addr_stable", bus.mem_addr_o, cur_addr);
        end
        if (bus.mem_ack_i) begin
          mem_seen = 1'b0;
          last_mem_ack_cyc = cyc;
        end
        if (bus.cpu_ack_o) begin
          check("ack_expected", 1, ack_expected);
          check("ack_has_request", bus.cpu_rd_i | bus.cpu_we_i, 1);
          check("ack_fault", bus.cpu_fault_o, exp_ack_fault);
          if (bus.cpu_rd_i && !exp_ack_fault) check("read_data", bus.cpu_data_o, exp_ack_data);
        end else if (bus.cpu_fault_o) begin
          check("fault_without_ack", 1, 0);
        end
        if (bus.flush_done_o) check("flush_done_expected", 1, flush_pending);
      end
    end
  end

  task automatic cpu_access(input logic [31:0] addr, input bit we, input logic [3:0] sel,
                            input logic [31:0] wd, input bit f_wb, input bit f_fill,
                            output logic [31:0] rdata, output bit flt, output int cycles);
    bit hit;
    bit eflt;
    logic [31:0] erd;
    model_access(addr, we, sel, wd, f_wb, f_fill, hit, eflt, erd);
    f_wb_flag     = f_wb;
    f_fill_flag   = f_fill;
    exp_ack_fault = eflt;
    exp_ack_data  = erd;
    ack_expected  = 1'b1;
    @(posedge clk);
    #1;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wd;
    bus.cpu_sel_i  = sel;
    bus.cpu_rd_i   = !we;
    bus.cpu_we_i   = we;
    cycles = 0;
    rdata  = '0;
    flt    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cpu_ack_o) begin
        rdata = bus.cpu_data_o;
        flt   = bus.cpu_fault_o;
        last_cpu_ack_cyc = cyc;
        break;
      end
      cycles++;
      if (cycles > 300) begin
        check("ack_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_rd_i = 1'b0;
    bus.cpu_we_i = 1'b0;
    ack_expected = 1'b0;
    if (hit) check("hit_zero_wait", cycles, 0);
    check("mem_txns_consumed", exp_mem.size(), 0);
  endtask

  task automatic do_flush(input bit with_miss, input logic [31:0] miss_addr);
    int n;
    bit seen;
    for (int i = 0; i < LINES; i++) begin
      if (m_valid[i] && m_dirty[i])
        exp_mem.push_back('{1'b1, {m_tag[i], 6'(i), 5'b0}, m_line[i]});
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    f_wb_flag     = 1'b0;
    f_fill_flag   = 1'b0;
    flush_pending = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    if (with_miss) begin
      bus.cpu_addr_i = miss_addr;
      bus.cpu_rd_i   = 1'b1;
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < LINES * (lat + 4) + 50) begin
      @(negedge clk);
      seen = bus.flush_done_o;
      n++;
    end
    check("flush_done_seen", seen, 1);
    @(posedge clk);
    #1;
    bus.flush_i   = 1'b0;
    bus.cpu_rd_i  = 1'b0;
    flush_pending = 1'b0;
    @(negedge clk);
    check("flush_done_one_cycle", bus.flush_done_o, 0);
    check("flush_txns_consumed", exp_mem.size(), 0);
  endtask

  initial begin
    logic [31:0]  rd;
    bit           flt;
    int           cy;
    int           base_rd;
    int           base_wr;
    logic [255:0] l;
    bit           hit;
    logic [31:0]  dummy;

    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_sel_i  = '0;
    bus.cpu_rd_i   = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.flush_i    = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd", bus.mem_rd_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_flush_done", bus.flush_done_o, 0);
    check("rst_cpu_fault", bus.cpu_fault_o, 0);
    check("rst_cpu_ack", bus.cpu_ack_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_data", bus.mem_data_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // cold read of 0x1004, fill word1 = DEADBEEF
    l = mem_line(32'h0000_1000);
    l[63:32] = 32'hDEAD_BEEF;
    bmem[32'h0000_1000] = l;
    cpu_access(32'h0000_1004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("cold_read_data", rd, 32'hDEAD_BEEF);
    check("cold_fill_addr", last_rd_addr, 32'h0000_1000);
    check("ack_one_after_mem_ack", last_cpu_ack_cyc, last_mem_ack_cyc + 1);

    // write hit with byte enables, then read back the merged word
    cpu_access(32'h0000_1004, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, rd, flt, cy);
    check("write_hit_wait", cy, 0);
    cpu_access(32'h0000_1004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("merged_read", rd, 32'hDEAD_5678);

    // conflict miss on the dirty line: write-back then fill
    cpu_access(32'h0000_1804, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("evict_addr", last_wr_addr, 32'h0000_1000);
    check("evict_word1", last_wr_data[63:32], 32'hDEAD_5678);
    check("refill_addr", last_rd_addr, 32'h0000_1800);

    // fill fault on a valid line leaves it valid with its old tag
    cpu_access(32'h0000_3004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, rd, flt, cy);
    check("fill_fault_flag", flt, 1);
    cpu_access(32'h0000_1804, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("after_fault_hit_wait", cy, 0);
    // fill fault on an invalid line leaves it invalid
    cpu_access(32'h0000_2040, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, rd, flt, cy);
    check("cold_fault_flag", flt, 1);
    base_rd = n_rd;
    cpu_access(32'h0000_2040, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("still_invalid_refetch", n_rd - base_rd, 1);

    // write-back fault keeps the victim dirty and resident
    cpu_access(32'h0000_1808, 1'b1, 4'hF, 32'hA1B2_C3D4, 1'b0, 1'b0, rd, flt, cy);
    cpu_access(32'h0000_5000, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, rd, flt, cy);
    check("wb_fault_flag", flt, 1);
    check("wb_fault_addr", last_wr_addr, 32'h0000_1800);
    cpu_access(32'h0000_1808, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("wb_fault_line_kept", rd, 32'hA1B2_C3D4);

    // flush: only the dirty line 0 goes out
    base_wr = n_wr;
    do_flush(1'b0, 32'h0);
    check("flush1_writes", n_wr - base_wr, 1);

    // dirty lines 3 and 63, clean line 5; flush beats a concurrent miss
    cpu_access(32'h0004_0064, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, rd, flt, cy);
    cpu_access(32'h0001_07E8, 1'b1, 4'b1100, 32'h7700_0000, 1'b0, 1'b0, rd, flt, cy);
    cpu_access(32'h0000_00A0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    base_wr = n_wr;
    wr_log.delete();
    do_flush(1'b1, 32'h0000_0140);
    check("flush2_writes", n_wr - base_wr, 2);
    if (wr_log.size() == 2) begin
      check("flush2_first", wr_log[0], 32'h0004_0060);
      check("flush2_second", wr_log[1], 32'h0001_07E0);
    end else begin
      check("flush2_log_size", wr_log.size(), 2);
    end

    // everything misses after the flush, and the written-back data returns
    base_rd = n_rd;
    cpu_access(32'h0004_0064, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("post_flush_miss", n_rd - base_rd, 1);
    check("post_flush_data", rd, 32'hCAFE_F00D);
    cpu_access(32'h0004_0064, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("prior_hit_wait", cy, 0);

    // reset in the middle of a fill
    lat = 20;
    model_access(32'h0000_2000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, hit, flt, dummy);
    @(posedge clk);
    #1;
    bus.cpu_addr_i = 32'h0000_2000;
    bus.cpu_rd_i   = 1'b1;
    cy = 0;
    while (!bus.mem_rd_o && cy < 20) begin
      @(negedge clk);
      cy++;
    end
    check("fill_started", bus.mem_rd_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_rd_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_rd", bus.mem_rd_o, 0);
    check("rst_abort_mem_addr", bus.mem_addr_o, 0);
    model_reset();
    exp_mem.delete();
    lat = 2;
    base_rd = n_rd;
    cpu_access(32'h0004_0064, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, flt, cy);
    check("after_rst_miss", n_rd - base_rd, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
